// File: rtl/tagged_assoc_btb_if.sv
// Lookup, update and flush signals of the tagged set-associative BTB.
// The frontend (master) drives PC/update/flush; the BTB (slave) returns per-slot predictions.
interface tagged_assoc_btb_if #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2
);
    logic                              flush_i;
    logic                              debug_mode_i;
    logic [VLEN-1:0]                   vpc_i;
    logic                              upd_valid_i;
    logic [VLEN-1:0]                   upd_pc_i;
    logic [VLEN-1:0]                   upd_target_i;
    logic [INSTR_PER_FETCH-1:0]        pred_valid_o;
    logic [INSTR_PER_FETCH*VLEN-1:0]   pred_target_o;
    logic                              flush_busy_o;
    logic                              dbg_flush_state_o;

    // Updates are fire-and-forget: upd_valid_i is sampled once per cycle, there is no
    // ready, and a request the BTB cannot take (debug, flush, sweep) is silently dropped.
    modport master (
        output flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_target_i,
        input  pred_valid_o, pred_target_o, flush_busy_o, dbg_flush_state_o
    );
    modport slave (
        input  flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_target_i,
        output pred_valid_o, pred_target_o, flush_busy_o, dbg_flush_state_o
    );
endinterface

// File: rtl/tagged_assoc_btb.sv
// Set-associative partial-tag BTB with per-set round-robin replacement and a
// one-set-per-cycle invalidate sweep.
module tagged_assoc_btb #(
    parameter int unsigned NR_ENTRIES      = 64,
    parameter int unsigned NR_WAYS         = 2,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned TAG_BITS        = 8,
    parameter int unsigned RVC             = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tagged_assoc_btb_if.slave bus
);
    localparam int unsigned OFFSET    = (RVC != 0) ? 1 : 2;
    localparam int unsigned ROW       = $clog2(INSTR_PER_FETCH);
    localparam int unsigned NR_SETS   = NR_ENTRIES / (NR_WAYS * INSTR_PER_FETCH);
    localparam int unsigned SET_BITS  = $clog2(NR_SETS);
    localparam int unsigned WAY_BITS  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int unsigned SLOT_BITS = (ROW > 0) ? ROW : 1;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

    function automatic logic [SET_BITS-1:0] pc_set(input logic [VLEN-1:0] pc);
        logic [VLEN-1:0] sh;
        sh = pc >> (OFFSET + ROW);
        return sh[SET_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [VLEN-1:0] pc);
        logic [VLEN-1:0] sh;
        sh = pc >> (OFFSET + ROW + SET_BITS);
        return sh[TAG_BITS-1:0];
    endfunction

    // Without compressed instructions every branch maps to slot 0.
    function automatic logic [SLOT_BITS-1:0] pc_slot(input logic [VLEN-1:0] pc);
        logic [VLEN-1:0] sh;
        sh = pc >> OFFSET;
        if (RVC == 0 || ROW == 0) return '0;
        return sh[SLOT_BITS-1:0];
    endfunction

    logic                r_valid  [NR_SETS][INSTR_PER_FETCH][NR_WAYS];
    logic [TAG_BITS-1:0] r_tag    [NR_SETS][INSTR_PER_FETCH][NR_WAYS];
    logic [VLEN-1:0]     r_target [NR_SETS][INSTR_PER_FETCH][NR_WAYS];
    logic [WAY_BITS-1:0] r_rr     [NR_SETS];

    state_e              r_state, w_state_next;
    logic [SET_BITS-1:0] r_fcnt, w_fcnt_next;

    logic [SET_BITS-1:0]             w_lk_set;
    logic [TAG_BITS-1:0]             w_lk_tag;
    logic [INSTR_PER_FETCH-1:0]      w_pred_valid;
    logic [INSTR_PER_FETCH*VLEN-1:0] w_pred_target;

    logic [SET_BITS-1:0]  w_upd_set;
    logic [SLOT_BITS-1:0] w_upd_slot;
    logic [TAG_BITS-1:0]  w_upd_tag;
    logic                 w_upd_hit;
    logic [WAY_BITS-1:0]  w_upd_hit_way;
    logic [WAY_BITS-1:0]  w_upd_way;
    logic                 w_accept;

    assign w_lk_set   = pc_set(bus.vpc_i);
    assign w_lk_tag   = pc_tag(bus.vpc_i);
    assign w_upd_set  = pc_set(bus.upd_pc_i);
    assign w_upd_slot = pc_slot(bus.upd_pc_i);
    assign w_upd_tag  = pc_tag(bus.upd_pc_i);

    // Ways are scanned from the top so the lowest-index hitting way wins.
    always_comb begin
        w_pred_valid  = '0;
        w_pred_target = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            for (int w = NR_WAYS - 1; w >= 0; w--) begin
                if (r_state == ST_IDLE && r_valid[w_lk_set][i][w] &&
                    r_tag[w_lk_set][i][w] == w_lk_tag) begin
                    w_pred_valid[i]                = 1'b1;
                    w_pred_target[i*VLEN +: VLEN]  = r_target[w_lk_set][i][w];
                end
            end
        end
    end

    always_comb begin
        w_upd_hit     = 1'b0;
        w_upd_hit_way = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_upd_set][w_upd_slot][w] &&
                r_tag[w_upd_set][w_upd_slot][w] == w_upd_tag) begin
                w_upd_hit     = 1'b1;
                w_upd_hit_way = WAY_BITS'(w);
            end
        end
    end

    assign w_upd_way = w_upd_hit ? w_upd_hit_way : r_rr[w_upd_set];
    assign w_accept  = bus.upd_valid_i && !bus.debug_mode_i &&
                       (r_state == ST_IDLE) && !bus.flush_i;

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    w_state_next = ST_FLUSH;
                    w_fcnt_next  = '0;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_i) begin
                    w_fcnt_next = '0;
                end else begin
                    w_fcnt_next = r_fcnt + SET_BITS'(1);
                    if (r_fcnt == SET_BITS'(NR_SETS - 1)) w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_fcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // Sweep and accepted updates never coincide: updates are only taken in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NR_SETS; s++) begin
                r_rr[s] <= '0;
                for (int i = 0; i < INSTR_PER_FETCH; i++)
                    for (int w = 0; w < NR_WAYS; w++)
                        r_valid[s][i][w] <= 1'b0;
            end
        end else begin
            if (r_state == ST_FLUSH) begin
                for (int i = 0; i < INSTR_PER_FETCH; i++)
                    for (int w = 0; w < NR_WAYS; w++)
                        r_valid[r_fcnt][i][w] <= 1'b0;
            end
            if (w_accept) begin
                r_valid[w_upd_set][w_upd_slot][w_upd_way] <= 1'b1;
                if (!w_upd_hit)
                    r_rr[w_upd_set] <= (r_rr[w_upd_set] == WAY_BITS'(NR_WAYS - 1)) ?
                                       '0 : r_rr[w_upd_set] + WAY_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_tag[w_upd_set][w_upd_slot][w_upd_way]    <= w_upd_tag;
            r_target[w_upd_set][w_upd_slot][w_upd_way] <= bus.upd_target_i;
        end
    end

    assign bus.pred_valid_o      = w_pred_valid;
    assign bus.pred_target_o     = w_pred_target;
    assign bus.flush_busy_o      = (r_state == ST_FLUSH);
    assign bus.dbg_flush_state_o = r_state;
endmodule
